// File: rtl/sm3_pkg.sv
// Shared types, constants and rotate/permutation helpers for the SM3 message-expansion stage.
package sm3_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StExpand
  } state_e;

  localparam int unsigned BlkWords = 16;
  localparam int unsigned Rounds   = 64;

  // Rotate by doubling the word so that n == 0 needs no special case.
  function automatic word_t rotl32(word_t x, int unsigned n);
    logic [63:0] d;
    d = {x, x} << (n % 32);
    return d[63:32];
  endfunction

  function automatic word_t p1(word_t x);
    return x ^ rotl32(x, 15) ^ rotl32(x, 23);
  endfunction

endpackage

// File: rtl/sm3_expnd_wgen.sv
// Combinational generator of the next expanded word from five sliding-window taps.
module sm3_expnd_wgen
  import sm3_pkg::*;
(
  input  word_t w0_i,
  input  word_t w3_i,
  input  word_t w7_i,
  input  word_t w10_i,
  input  word_t w13_i,
  output word_t wnew_o
);

  word_t p1_in;

  always_comb begin
    p1_in  = w0_i ^ w7_i ^ rotl32(w13_i, 15);
    wnew_o = p1(p1_in) ^ rotl32(w3_i, 7) ^ w10_i;
  end

endmodule

// File: rtl/sm3_expnd_core.sv
// SM3 message expansion: loads a 16-word block, then streams 64 (Wj, W'j) round pairs
// from a 16-entry sliding window.
module sm3_expnd_core
  import sm3_pkg::*;
#(
  parameter int unsigned DW        = 32,
  parameter int unsigned BLK_WORDS = BlkWords,
  parameter int unsigned ROUNDS    = Rounds
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] pad_otpt_d_i,
  input  logic          pad_otpt_vld_i,
  input  logic          pad_otpt_lst_i,
  output logic          pad_otpt_ena_o,
  output logic [DW-1:0] expnd_otpt_wj_o,
  output logic [DW-1:0] expnd_otpt_wjj_o,
  output logic          expnd_otpt_vld_o,
  input  logic          expnd_otpt_rdy_i,
  output logic          expnd_otpt_lst_o,
  output logic [5:0]    expnd_otpt_rnd_o
);

  state_e state_q, state_d;

  logic [DW-1:0] win_q [BLK_WORDS];
  logic [DW-1:0] win_d [BLK_WORDS];
  logic [3:0]    ld_cnt_q, ld_cnt_d;
  logic [5:0]    rnd_q, rnd_d;
  logic          lst_q, lst_d;

  logic          load_fire, exp_fire;
  logic          last_word, last_rnd;
  word_t         wnew;

  assign load_fire = (state_q == StLoad) && pad_otpt_vld_i;
  assign exp_fire  = (state_q == StExpand) && expnd_otpt_rdy_i;
  assign last_word = (ld_cnt_q == 4'(BLK_WORDS - 1));
  assign last_rnd  = (rnd_q == 6'(ROUNDS - 1));

  sm3_expnd_wgen u_wgen (
    .w0_i  (win_q[0]),
    .w3_i  (win_q[3]),
    .w7_i  (win_q[7]),
    .w10_i (win_q[10]),
    .w13_i (win_q[13]),
    .wnew_o(wnew)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:   state_d = StLoad;
      StLoad:   if (load_fire && last_word) state_d = StExpand;
      StExpand: if (exp_fire && last_rnd) state_d = StLoad;
      default:  state_d = StIdle;
    endcase
  end

  // Output logic; every output is a function of registered state only
  always_comb begin
    pad_otpt_ena_o   = 1'b0;
    expnd_otpt_vld_o = 1'b0;
    expnd_otpt_wj_o  = '0;
    expnd_otpt_wjj_o = '0;
    expnd_otpt_lst_o = 1'b0;
    expnd_otpt_rnd_o = rnd_q;
    case (state_q)
      StLoad: pad_otpt_ena_o = 1'b1;
      StExpand: begin
        expnd_otpt_vld_o = 1'b1;
        expnd_otpt_wj_o  = win_q[0];
        expnd_otpt_wjj_o = win_q[0] ^ win_q[4];
        expnd_otpt_lst_o = lst_q & last_rnd;
      end
      default: ;
    endcase
  end

  // Datapath next-state: window load/shift, counters, last-block flag
  always_comb begin
    win_d    = win_q;
    ld_cnt_d = ld_cnt_q;
    rnd_d    = rnd_q;
    lst_d    = lst_q;

    if (load_fire) begin
      win_d[ld_cnt_q] = pad_otpt_d_i;
      ld_cnt_d        = ld_cnt_q + 4'd1;
      if (last_word) begin
        lst_d    = pad_otpt_lst_i;
        rnd_d    = '0;
        ld_cnt_d = '0;
      end
    end

    if (exp_fire) begin
      for (int i = 0; i < int'(BLK_WORDS) - 1; i++) begin
        win_d[i] = win_q[i+1];
      end
      win_d[BLK_WORDS-1] = wnew;
      rnd_d              = rnd_q + 6'd1;
      if (last_rnd) begin
        lst_d    = 1'b0;
        rnd_d    = '0;
        ld_cnt_d = '0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(BLK_WORDS); i++) begin
        win_q[i] <= '0;
      end
      ld_cnt_q <= '0;
      rnd_q    <= '0;
      lst_q    <= 1'b0;
    end else begin
      win_q    <= win_d;
      ld_cnt_q <= ld_cnt_d;
      rnd_q    <= rnd_d;
      lst_q    <= lst_d;
    end
  end

endmodule
